bus_dev_port: RTL
=================

Name: bus_dev_port

Overview:
- Per-device endpoint FIFO pair that connects one device to one slot of the bus generator/arbiter (bs_gnrtr_n_rbtr).
- TX FIFO buffers device packets and presents them to the arbiter through pndng/D_pop/pop.
- RX FIFO captures packets the arbiter delivers through push/D_push, after destination-ID filtering.
- One instance is placed per bus device (index 0..drvrs-1).

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID.
- depth, 8, entries per FIFO (TX and RX); power of two, minimum 2.
- dev_id, 0, this device's 8-bit ID.
- broadcast, 8'hFF, destination ID that every port accepts.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_wr  in  1  device write strobe for the TX FIFO.
- tx_data  in  pckg_sz  packet to transmit.
- tx_full  out  1  TX FIFO holds depth entries.
- pndng  out  1  TX FIFO not empty (to arbiter).
- D_pop  out  pckg_sz  TX head packet (to arbiter).
- pop  in  1  arbiter consumes the TX head.
- push  in  1  arbiter delivers a packet.
- D_push  in  pckg_sz  delivered packet.
- rx_rd  in  1  device read strobe for the RX FIFO.
- rx_data  out  pckg_sz  RX head packet.
- rx_empty  out  1  RX FIFO holds no entries.
- rx_drop_cnt  out  16  count of packets lost to RX overflow; saturating.
- rx_filt_cnt  out  16  count of packets rejected by the ID filter; saturating.

Behaviour:
- Reset (synchronous), cycle after reset sampled high:
  - pointers and counts = 0; pndng = 0, tx_full = 0, rx_empty = 1; both counters = 0.
  - D_pop and rx_data = 0 (FIFO storage need not be cleared; outputs are masked to 0 while empty).
  - Reset mid-operation discards all queued packets; strobes are ignored while reset = 1.
- TX FIFO:
  - First-word-fall-through: D_pop shows the head combinationally; pndng = (tx_count != 0).
  - Write accepted iff tx_wr && !tx_full. A write while full is ignored even if pop is high in the same cycle; no TX error flag.
  - pop with pndng = 1 advances the read pointer. pop while empty is ignored.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - A written packet is visible on D_pop/pndng one cycle after the write edge (1-cycle latency).
  - Pointers wrap modulo depth.
  - Count register width is clog2(depth)+1, so full and empty are distinct.
- RX filter and FIFO:
  - On push: dest = D_push[pckg_sz-1 -: 8]. Packet is eligible iff dest == dev_id or dest == broadcast.
  - Ineligible push: packet discarded; rx_filt_cnt increments, saturating at 16'hFFFF.
  - Eligible push with RX not full, or with RX full and rx_rd in the same cycle: packet stored.
  - Eligible push with RX full and no rx_rd: packet dropped; rx_drop_cnt increments, saturating.
  - rx_rd with !rx_empty pops the head; rx_data is first-word-fall-through; rx_empty = (rx_count == 0).
  - Stored packet is visible on rx_data one cycle after the push edge.
  - No backpressure to the arbiter: push is always taken in the cycle it is asserted.
- No state machine beyond the FIFO counters. All outputs are registers or decode directly from registered state; no combinational input-to-output path except through the head mux.

Decomposition:
- Package bus_port_pkg: localparam ID_W = 8, function dest_of(pkt), typedef cnt16_t.
- One sub-module: bus_fifo_core.
  - Parameters: width, depth.
  - Ports: clk, reset, wr, wdata, rd, rdata, full, empty, count.
  - Instantiated twice: TX with wr = tx_wr && !tx_full; RX with wr = eligible && (!full || rx_rd).

Test Plan:
- Reset, then tx_wr with 16'h0312 for 1 cycle -> next cycle pndng = 1 and D_pop = 16'h0312; pop 1 cycle -> pndng = 0, D_pop = 0.
- Write 9 packets 16'h0100..16'h0108 (depth 8), no pop -> tx_full = 1 after the 8th write; the 9th is ignored; 8 pops return 16'h0100..16'h0107 in order.
- dev_id = 2: push 16'h0255, then 16'h0355, then 16'hFF77 -> RX holds 16'h0255 and 16'hFF77; rx_filt_cnt = 1; rx_drop_cnt = 0.
- Fill RX with 8 eligible pushes, push a 9th without rx_rd -> rx_drop_cnt = 1; repeat the 9th push together with rx_rd -> packet stored, rx_drop_cnt stays 1.
- Simultaneous tx_wr and pop with 3 entries queued, held for 20 cycles -> count stays 3, pointers wrap, data order preserved.
- Assert reset with 5 TX and 4 RX entries queued -> next cycle pndng = 0, rx_empty = 1, both counters = 0.

Source files
------------

// File: rtl/bus_port_pkg.sv
// Shared types and helpers for the bus device port.
package bus_port_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned PKT_MAX_W = 64;

  typedef logic [15:0] cnt16_t;

  // Destination ID sits in the top ID_W bits of a w-bit packet.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned           w);
    return ID_W'(pkt >> (w - ID_W));
  endfunction

endpackage

// File: rtl/bus_fifo_core.sv
// First-word-fall-through FIFO; head is masked to zero while empty.
module bus_fifo_core #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [width-1:0]       wdata,
  input  logic                   rd,
  output logic [width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr_c, do_rd_c;

  // A write is taken when there is room, or when a read frees a slot this cycle.
  always_comb begin
    do_rd_c  = rd && (count_q != '0);
    do_wr_c  = wr && ((count_q != CNT_W'(depth)) || do_rd_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr_c, do_rd_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && do_wr_c) mem_q[wr_ptr_q] <= wdata;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(depth));
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_dev_port.sv
// Per-device endpoint: TX FIFO toward the arbiter, ID-filtered RX FIFO from it.
module bus_dev_port
  import bus_port_pkg::*;
#(
  parameter int unsigned    pckg_sz   = 16,
  parameter int unsigned    depth     = 8,
  parameter logic [ID_W-1:0] dev_id    = 8'd0,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [15:0]        rx_drop_cnt,
  output logic [15:0]        rx_filt_cnt
);

  localparam int unsigned CNT_W = $clog2(depth) + 1;

  logic [ID_W-1:0]  dest_c;
  logic             id_match_c, eligible_c, filt_c, drop_c;
  logic             tx_wr_c, rx_wr_c, rx_full_c;
  logic             tx_empty_w, rx_full_w;
  logic [CNT_W-1:0] tx_count_w, rx_count_w;
  cnt16_t           drop_q, drop_d, filt_q, filt_d;
  logic             unused_ok_c;

  // Destination filter and FIFO write qualification.
  always_comb begin
    dest_c     = dest_of(PKT_MAX_W'(D_push), pckg_sz);
    id_match_c = (dest_c == dev_id) || (dest_c == broadcast);
    eligible_c = push && id_match_c;
    filt_c     = push && !id_match_c;
    rx_full_c  = (rx_count_w == CNT_W'(depth));
    drop_c     = eligible_c && rx_full_c && !rx_rd;
    rx_wr_c    = eligible_c && (!rx_full_c || rx_rd);
    tx_wr_c    = tx_wr && !tx_full;
  end

  bus_fifo_core #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr_c),
    .wdata (tx_data),
    .rd    (pop),
    .rdata (D_pop),
    .full  (tx_full),
    .empty (tx_empty_w),
    .count (tx_count_w)
  );

  bus_fifo_core #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_wr_c),
    .wdata (D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (rx_full_w),
    .empty (rx_empty),
    .count (rx_count_w)
  );

  // Saturating next values for the loss counters.
  always_comb begin
    drop_d = drop_q;
    filt_d = filt_q;
    if (drop_c && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    if (filt_c && (filt_q != 16'hFFFF)) filt_d = filt_q + 16'd1;
  end

  // Loss counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      filt_q <= '0;
    end else begin
      drop_q <= drop_d;
      filt_q <= filt_d;
    end
  end

  assign pndng       = (tx_count_w != '0);
  assign rx_drop_cnt = drop_q;
  assign rx_filt_cnt = filt_q;
  assign unused_ok_c = tx_empty_w ^ rx_full_w;

endmodule
